// File: rtl/line_encoder_4to2.sv
// Registered, debounced 4-to-2 line encoder with a two-flop input synchronizer.
// Compile-time option ENC_PRIORITY_EN: multi-hot inputs resolve to the highest index instead of raising ERR.
module line_encoder_4to2 #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] I,
    output logic [1:0] O,
    output logic       V,
    output logic       STB,
    output logic       ERR
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3
`ifndef ENC_PRIORITY_EN
        ,
        ST_BLOCK   = 3'd4
`endif
    } state_t;

    localparam logic [CNT_W-1:0] CNT_DEB = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       is_q, is_d;
    logic [3:0]       snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       o_q, o_d;
    logic             v_q, v_d;
    logic             stb_q, stb_d;
    logic             err_q, err_d;

    function automatic logic [1:0] hi_index(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    always_comb begin
        sync1_d = I;
        is_d    = sync1_q;
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        v_d     = v_q;
        stb_d   = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (is_q != 4'd0) begin
                    state_d = ST_SETTLE;
                    snap_d  = is_q;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (is_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else if (is_q != snap_q) begin
                    snap_d = is_q;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_DEB) begin
`ifdef ENC_PRIORITY_EN
                    state_d = ST_HOLD;
                    o_d     = hi_index(snap_q);
                    v_d     = 1'b1;
                    stb_d   = 1'b1;
`else
                    // More than one bit set: x & (x-1) clears only the lowest set bit.
                    if ((snap_q & (snap_q - 4'd1)) != 4'd0) begin
                        state_d = ST_BLOCK;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                        o_d     = hi_index(snap_q);
                        v_d     = 1'b1;
                        stb_d   = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (is_q == 4'd0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (is_q != 4'd0) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_DEB) begin
                    state_d = ST_IDLE;
                    v_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifndef ENC_PRIORITY_EN
            // Counter restarts from zero on every nonzero sample so only a clean zero run exits.
            ST_BLOCK: begin
                if (is_q != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_DEB) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sync1_q <= 4'd0;
            is_q    <= 4'd0;
            snap_q  <= 4'd0;
            cnt_q   <= '0;
            o_q     <= 2'd0;
            v_q     <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            is_q    <= is_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            v_q     <= v_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    assign O   = o_q;
    assign V   = v_q;
    assign STB = stb_q;
`ifdef ENC_PRIORITY_EN
    assign ERR = 1'b0;
`else
    assign ERR = err_q;
`endif

endmodule
